// File: rtl/operand_seq_pkg.sv
// operand_seq_pkg: sequencer state encoding, LFSR/MISR taps, 60-bit operand field layout and step functions
package operand_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DONE} state_t;
  typedef struct packed {
    logic [3:0] a0;
    logic [4:0] a1;
    logic [5:0] a2;
    logic [3:0] a3;
    logic [4:0] a4;
    logic [5:0] a5;
    logic [3:0] b0;
    logic [4:0] b1;
    logic [5:0] b2;
    logic [3:0] b3;
    logic [4:0] b4;
    logic [5:0] b5;
  } operand_t;
  localparam int OPERANDS_W = $bits(operand_t);
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], ^(l & LFSR_TAPS)};
  endfunction
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [30:0] d);
    return {s[30:0], ^(s & MISR_TAPS)} ^ {1'b0, d};
  endfunction
endpackage

// File: rtl/sig_misr32.sv
// sig_misr32: 32-bit MISR; ports clk, clear (sync, wins over enable), enable, data[30:0] in, signature[31:0] out
module sig_misr32 import operand_seq_pkg::*; (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic [30:0] data,
  output logic [31:0] signature
);
  always_ff @(posedge clk)
    if (clear) signature <= '0;
    else if (enable) signature <= misr_step(signature, data);
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: LFSR operand generator + MISR compactor; ports clk, resetn, start, abort, num_vectors, expected_sig, y in; operands, busy, done, pass, signature, vec_count out
module operand_sequencer import operand_seq_pkg::*; #(
  parameter int          NUM_VECTORS_W = 16,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [63:0] LFSR_SEED     = 64'h0000_0000_0000_0001
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_VECTORS_W-1:0] num_vectors,
  input  logic [31:0]              expected_sig,
  output logic [OPERANDS_W-1:0]    operands,
  input  logic [30:0]              y,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [31:0]              signature,
  output logic [NUM_VECTORS_W-1:0] vec_count
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  state_t state;
  logic [63:0] lfsr;
  logic [3:0] settle_cnt;
  logic [NUM_VECTORS_W-1:0] num_lat;
  logic [31:0] exp_lat;
  logic [NUM_VECTORS_W-1:0] vec_next;
  logic accept, capture, last, empty;
  assign accept = (state == IDLE || state == DONE) && start && !abort;
  assign capture = state == CAPTURE && !abort;
  assign vec_next = vec_count + 1'b1;
  assign last = vec_next == num_lat;
  assign empty = num_vectors == '0;
  sig_misr32 u_misr (
    .clk       (clk),
    .clear     (!resetn || accept),
    .enable    (capture),
    .data      (y),
    .signature (signature)
  );
  // pass is predicted from the MISR's next value so it rises together with done
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      vec_count <= '0;
      operands <= '0;
      num_lat <= '0;
      exp_lat <= '0;
      settle_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else case (state)
      IDLE, DONE: if (start) begin
        vec_count <= '0;
        num_lat <= num_vectors;
        exp_lat <= expected_sig;
        state <= empty ? DONE : LOAD;
        busy <= !empty;
        done <= empty;
        pass <= empty && expected_sig == '0;
      end
      LOAD: begin
        operands <= lfsr[OPERANDS_W-1:0];
        lfsr <= lfsr_step(lfsr);
        state <= SETTLE_CYCLES == 0 ? CAPTURE : SETTLE;
        settle_cnt <= SETTLE_LAST;
      end
      SETTLE: begin
        state <= settle_cnt == '0 ? CAPTURE : SETTLE;
        settle_cnt <= settle_cnt - 1'b1;
      end
      CAPTURE: begin
        vec_count <= vec_next;
        state <= last ? DONE : LOAD;
        busy <= !last;
        done <= last;
        pass <= last && misr_step(signature, y) == exp_lat;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed and randomized runs of operand_sequencer checked against a behavioural model
module tb_operand_sequencer;
  localparam int S = 2;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [31:0] expected_sig = '0;
  logic [59:0] operands;
  logic [30:0] y;
  logic busy, done, pass;
  logic [31:0] signature;
  logic [15:0] vec_count;
  logic y_fn = 1'b0;
  logic [30:0] y_const = '0;
  logic [30:0] key = '0;
  int vectors = 0;
  int errors = 0;
  logic [63:0] m_lfsr = 64'h1;
  logic [59:0] mops[$];
  logic [31:0] msig;
  always #5 clk = ~clk;
  function automatic logic [30:0] dp(input logic [59:0] op, input logic [30:0] k);
    return op[30:0] ^ {op[59:31], 2'b00} ^ k;
  endfunction
  assign y = y_fn ? dp(operands, key) : y_const;
  operand_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .num_vectors  (num_vectors),
    .expected_sig (expected_sig),
    .operands     (operands),
    .y            (y),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .vec_count    (vec_count)
  );
  function automatic logic [63:0] lfsr_nx(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction
  function automatic logic [31:0] misr_nx(input logic [31:0] m, input logic [30:0] d);
    return {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ {1'b0, d};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic predict(input int n);
    mops.delete();
    msig = '0;
    for (int i = 0; i < n; i++) begin
      mops.push_back(m_lfsr[59:0]);
      m_lfsr = lfsr_nx(m_lfsr);
      msig = misr_nx(msig, y_fn ? dp(mops[i], key) : y_const);
    end
  endtask
  task automatic run(input int n, input bit use_model, input logic [31:0] ev, input string tag);
    int cyc;
    int k;
    predict(n);
    if (use_model) ev = msig;
    @(negedge clk);
    start = 1'b1;
    num_vectors = 16'(n);
    expected_sig = ev;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    k = 0;
    chk({tag, ".busy_at_start"}, busy, n != 0);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (k < n && cyc == 1 + k * (S + 2)) begin
        chk({tag, ".operands"}, operands, mops[k]);
        k++;
      end
    end
    chk({tag, ".cycles"}, cyc, n * (S + 2));
    chk({tag, ".signature"}, signature, msig);
    chk({tag, ".vec_count"}, vec_count, n);
    chk({tag, ".pass"}, pass, msig == ev);
    chk({tag, ".busy_done"}, busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.signature", signature, 0);
    chk("rst.vec_count", vec_count, 0);
    chk("rst.operands", operands, 0);
    resetn = 1'b1;
    run(2, 1'b1, 0, "seed2");
    chk("seed2.last_operand", operands, 60'h2);
    y_const = 31'h1;
    run(1, 1'b1, 0, "y1n1");
    chk("y1n1.sig_const", signature, 32'h1);
    run(2, 1'b1, 0, "y1n2");
    chk("y1n2.sig_const", signature, 32'h2);
    y_const = '0;
    run(5, 1'b0, 32'h0, "pass0");
    chk("pass0.pass_const", pass, 1);
    run(5, 1'b0, 32'h1, "pass1");
    chk("pass1.pass_const", pass, 0);
    run(0, 1'b0, 32'h0, "n0");
    chk("n0.done", done, 1);
    y_fn = 1'b1;
    key = 31'($urandom);
    predict(2);
    m_lfsr = lfsr_nx(m_lfsr);
    @(negedge clk);
    start = 1'b1;
    num_vectors = 16'd10;
    expected_sig = '0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("abort.vc1_start_held", vec_count, 1);
    repeat (3) @(negedge clk);
    chk("abort.vc2", vec_count, 2);
    chk("abort.busy", busy, 1);
    chk("abort.op2", operands, mops[1]);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort.busy_after", busy, 0);
    chk("abort.done_after", done, 0);
    chk("abort.vc_kept", vec_count, 2);
    chk("abort.sig_kept", signature, msig);
    @(negedge clk);
    chk("abort.idle_stays", busy, 0);
    run(1, 1'b1, 0, "pre_done_abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("done_abort.done", done, 0);
    chk("done_abort.pass", pass, 0);
    chk("done_abort.vc", vec_count, 1);
    y_fn = 1'b0;
    y_const = 31'h5;
    @(negedge clk);
    start = 1'b1;
    num_vectors = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstrun.busy", busy, 1);
    resetn = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    chk("rstrun.busy_after", busy, 0);
    chk("rstrun.sig_after", signature, 0);
    chk("rstrun.done_after", done, 0);
    chk("rstrun.vc_after", vec_count, 0);
    chk("rstrun.op_after", operands, 0);
    m_lfsr = 64'h1;
    run(1, 1'b1, 0, "post_rst");
    chk("post_rst.operand_const", operands, 60'h1);
    y_fn = 1'b1;
    for (int r = 0; r < 8; r++) begin
      key = 31'($urandom);
      run(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), $urandom, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter NUM_VECTORS_W, default 16, width of the vector-count input.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, range 0..15; idle cycles between driving a vector and capturing y.
REQ-003 SHALL have parameter LFSR_SEED, default 64'h0000_0000_0000_0001; a value of 0 is illegal.
REQ-004 Port clk, input, 1: sole clock, all state on rising edge.
REQ-005 Port resetn, input, 1: reset, synchronous, active-low.
REQ-006 Port start, input, 1: begin a run; sampled only in IDLE and DONE.
REQ-007 Port abort, input, 1: terminate the run in progress.
REQ-008 Port num_vectors, input, NUM_VECTORS_W: vectors per run; latched on accepted start.
REQ-009 Port expected_sig, input, 32: reference signature; latched on accepted start.
REQ-010 Port operands, output, 60: {a0[3:0],a1[4:0],a2[5:0],a3[3:0],a4[4:0],a5[5:0],b0[3:0],b1[4:0],b2[5:0],b3[3:0],b4[4:0],b5[5:0]}, a0 at MSB.
REQ-011 Port y, input, 31: combinational result of the datapath under test.
REQ-012 Port busy, output, 1: high in LOAD, SETTLE and CAPTURE.
REQ-013 Port done, output, 1: high in DONE.
REQ-014 Port signature, output, 32: current MISR value.
REQ-015 Port pass, output, 1: in DONE, signature == latched expected_sig; 0 elsewhere.
REQ-016 Port vec_count, output, NUM_VECTORS_W: vectors captured in the current or last run.

Function
REQ-017 States SHALL be IDLE, LOAD, SETTLE, CAPTURE and DONE.
REQ-018 IDLE/DONE with start=1: SHALL clear the MISR and vec_count, latch inputs, and go to LOAD; if num_vectors==0, SHALL go to DONE instead.
REQ-019 LOAD SHALL register operands <= lfsr[59:0], advance the LFSR once, then go to SETTLE, or to CAPTURE when SETTLE_CYCLES==0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, holding operands stable.
REQ-021 CAPTURE SHALL perform misr <= {misr[30:0], misr[31]^misr[21]^misr[1]^misr[0]} ^ {1'b0, y} and increment vec_count.
REQ-022 CAPTURE SHALL go to DONE when the incremented vec_count equals num_vectors, else to LOAD.
REQ-023 LFSR step SHALL be lfsr <= {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}.
REQ-024 The LFSR SHALL NOT be reseeded between runs; consecutive runs continue the sequence.
REQ-025 A run SHALL take num_vectors*(SETTLE_CYCLES+2) cycles from the start-accept edge to done=1.
REQ-026 DONE SHALL hold done, pass, signature, vec_count and operands until the next accepted start.
REQ-027 abort=1 in LOAD/SETTLE/CAPTURE SHALL go to IDLE next cycle, keeping partial signature and vec_count; no capture occurs on that edge.
REQ-028 abort SHALL take priority over start; abort in IDLE/DONE SHALL move to IDLE.
REQ-029 start while busy SHALL be ignored.
REQ-030 vec_count SHALL NOT wrap; the terminal compare in REQ-022 ends the run first.

Reset
REQ-031 resetn=0 at a clock edge SHALL set state IDLE, lfsr=LFSR_SEED, misr=0, vec_count=0, operands=0, latched values=0.
REQ-032 After reset, busy=0, done=0, pass=0, signature=0.
REQ-033 Reset mid-run SHALL take effect on that edge, overriding start and abort.

Structure
REQ-034 State encoding, LFSR/MISR tap constants and the 60-bit operand field offsets SHALL live in a shared package, operand_seq_pkg.
REQ-035 The MISR SHALL be a sub-module, sig_misr32 (clear, enable, 31-bit data in, 32-bit signature out).
REQ-036 All outputs SHALL be registered; y is the only combinational input path.

Verification
REQ-037 Bench SHALL cover: reset, then start with num_vectors=2 and default seed -> operands=60'h1 after LOAD, then 60'h2; done after 8 cycles.
REQ-038 Bench SHALL cover: y tied to 31'h1, num_vectors=1 -> signature 32'h00000001; with num_vectors=2 -> 32'h00000002.
REQ-039 Bench SHALL cover: y tied to 0, expected_sig=0, num_vectors=5 -> pass=1, vec_count=5; expected_sig=1 -> pass=0.
REQ-040 Bench SHALL cover: num_vectors=0 -> done the cycle after start, signature=0, vec_count=0.
REQ-041 Bench SHALL cover: abort in the SETTLE of vector 3 of 10 -> IDLE next cycle, vec_count=2, done=0; start held high during busy is ignored.
REQ-042 Bench SHALL cover: resetn=0 in CAPTURE -> busy=0, signature=0 next cycle; the next run restarts operands at 60'h1.
